// File: rtl/regfile_rd_seq.sv
// Burst read sequencer: walks a register file from base_i for len_i entries and
// streams the data out on a valid/ready port. Optional clear pulse via REGFILE_RD_CLR_EN.
module regfile_rd_seq #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [AW-1:0] base_i,
  input  logic [AW:0]   len_i,
  input  logic          abort_i,
  output logic [AW-1:0] raddr_o,
  input  logic [DW-1:0] rdata_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  input  logic          ready_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          clr_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   rem_q, rem_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (start_i) begin
          ptr_d   = base_i;
          rem_d   = len_i;
          state_d = (len_i != '0) ? READ : DONE;
        end
      end

      READ: begin
        // Abort dominates; a beat handshaken in this cycle is simply taken as consumed.
        if (abort_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (valid_q && ready_i && rem_q == '0) begin
          valid_d = 1'b0;
          state_d = DONE;
        end else if (rem_q != '0 && (!valid_q || ready_i)) begin
          data_d  = rdata_i;
          valid_d = 1'b1;
          ptr_d   = ptr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
        end else if (!valid_q && rem_q == '0) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign raddr_o = ptr_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);

`ifdef REGFILE_RD_CLR_EN
  // Remembers whether the burst in flight was non-empty, so a zero-length request never clears.
  logic nz_q, nz_d;

  always_comb begin
    nz_d = nz_q;
    if (state_q == IDLE && start_i) begin
      nz_d = (len_i != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nz_q <= 1'b0;
    end else begin
      nz_q <= nz_d;
    end
  end

  assign clr_o = (state_q == DONE) && nz_q;
`else
  assign clr_o = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_rd_seq.sv
// Directed bench for regfile_rd_seq: register file model mem[k] = 8'h10 + k,
// hand-computed beat sequences, stalls, wrap, abort and mid-burst reset.
module tb_regfile_rd_seq;

  localparam int AW = 3;
  localparam int DW = 8;

`ifdef REGFILE_RD_CLR_EN
  localparam logic CLR_EXP = 1'b1;
`else
  localparam logic CLR_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [AW-1:0] base_i;
  logic [AW:0]   len_i;
  logic          abort_i;
  logic [AW-1:0] raddr_o;
  logic [DW-1:0] rdata_i;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          ready_i;
  logic          busy_o;
  logic          done_o;
  logic          clr_o;

  int n_vec = 0;
  int n_err = 0;

  regfile_rd_seq #(.AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .base_i  (base_i),
    .len_i   (len_i),
    .abort_i (abort_i),
    .raddr_o (raddr_o),
    .rdata_i (rdata_i),
    .valid_o (valid_o),
    .data_o  (data_o),
    .ready_i (ready_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .clr_o   (clr_o)
  );

  always #5 clk = ~clk;

  // Register file with combinational read: mem[k] = 8'h10 + k.
  assign rdata_i = 8'h10 + {5'd0, raddr_o};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; on return we are in cycle c+1.
  task automatic launch(input logic [AW-1:0] b, input logic [AW:0] l);
    base_i  = b;
    len_i   = l;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  logic [7:0] wrap_exp [8];
  logic [7:0] stall_exp [7];
  logic       stall_rdy [7];

  initial begin
    wrap_exp  = '{8'h16, 8'h17, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    stall_exp = '{8'h10, 8'h11, 8'h11, 8'h11, 8'h11, 8'h12, 8'h13};
    stall_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; start_i = 1'b0; base_i = '0; len_i = '0; abort_i = 1'b0; ready_i = 1'b1;
    #1;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_raddr", 32'(raddr_o), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // base=2 len=4: beats 12..15 at c+2..c+5, done at c+6; stray start in READ ignored.
    launch(3'd2, 4'd4);
    check("s1_c1_valid", 32'(valid_o), 32'd0);
    check("s1_c1_raddr", 32'(raddr_o), 32'd2);
    check("s1_c1_busy", 32'(busy_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin base_i = 3'd7; len_i = 4'd1; start_i = 1'b1; end
      tick();
      start_i = 1'b0;
      check($sformatf("s1_beat%0d_valid", i), 32'(valid_o), 32'd1);
      check($sformatf("s1_beat%0d_data", i), 32'(data_o), 32'h12 + 32'(i));
      check($sformatf("s1_beat%0d_done", i), 32'(done_o), 32'd0);
    end
    tick();
    check("s1_done", 32'(done_o), 32'd1);
    check("s1_done_valid", 32'(valid_o), 32'd0);
    check("s1_clr", 32'(clr_o), 32'(CLR_EXP));
    tick();
    check("s1_done_end", 32'(done_o), 32'd0);
    check("s1_idle", 32'(busy_o), 32'd0);

    // base=6 len=8: full wrap.
    launch(3'd6, 4'd8);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("s2_beat%0d", i), 32'(data_o), 32'(wrap_exp[i]));
      check($sformatf("s2_beat%0d_done", i), 32'(done_o), 32'd0);
    end
    tick();
    check("s2_done", 32'(done_o), 32'd1);
    tick();
    check("s2_done_once", 32'(done_o), 32'd0);

    // base=0 len=4 with ready low for 3 cycles after the first beat.
    launch(3'd0, 4'd4);
    for (int i = 0; i < 7; i++) begin
      tick();
      ready_i = stall_rdy[i];
      check($sformatf("s3_cyc%0d_valid", i), 32'(valid_o), 32'd1);
      check($sformatf("s3_cyc%0d_data", i), 32'(data_o), 32'(stall_exp[i]));
    end
    tick();
    check("s3_done", 32'(done_o), 32'd1);
    check("s3_valid_low", 32'(valid_o), 32'd0);
    tick();

    // Zero-length burst: done at c+1, no data, no clear.
    launch(3'd4, 4'd0);
    check("s4_done", 32'(done_o), 32'd1);
    check("s4_valid", 32'(valid_o), 32'd0);
    check("s4_clr", 32'(clr_o), 32'd0);
    tick();
    check("s4_idle", 32'(busy_o), 32'd0);

    // Abort after two beats of len=5, then a new burst.
    launch(3'd0, 4'd5);
    tick();
    check("s5_beat0", 32'(data_o), 32'h10);
    tick();
    check("s5_beat1", 32'(data_o), 32'h11);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("s5_abort_valid", 32'(valid_o), 32'd0);
    check("s5_abort_busy", 32'(busy_o), 32'd0);
    check("s5_abort_done", 32'(done_o), 32'd0);
    check("s5_abort_clr", 32'(clr_o), 32'd0);
    tick();
    check("s5_no_late_done", 32'(done_o), 32'd0);
    abort_i = 1'b1;
    launch(3'd3, 4'd1);
    abort_i = 1'b0;
    check("s5_restart_busy", 32'(busy_o), 32'd1);
    tick();
    check("s5_restart_data", 32'(data_o), 32'h13);
    tick();
    check("s5_restart_done", 32'(done_o), 32'd1);
    tick();

    // Reset mid-burst, then an immediate start on the first edge after release.
    launch(3'd0, 4'd4);
    tick();
    check("s6_pre_valid", 32'(valid_o), 32'd1);
    rst = 1'b1;
    #1;
    check("s6_rst_valid", 32'(valid_o), 32'd0);
    check("s6_rst_data", 32'(data_o), 32'd0);
    check("s6_rst_busy", 32'(busy_o), 32'd0);
    check("s6_rst_raddr", 32'(raddr_o), 32'd0);
    check("s6_rst_done", 32'(done_o), 32'd0);
    #1;
    rst = 1'b0;
    launch(3'd5, 4'd3);
    check("s6_accept", 32'(busy_o), 32'd1);
    check("s6_raddr", 32'(raddr_o), 32'd5);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("s6_beat%0d", i), 32'(data_o), 32'h15 + 32'(i));
      check($sformatf("s6_beat%0d_clr", i), 32'(clr_o), 32'd0);
    end
    tick();
    check("s6_done", 32'(done_o), 32'd1);
    check("s6_clr", 32'(clr_o), 32'(CLR_EXP));
    tick();
    check("s6_clr_end", 32'(clr_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
